// File: rtl/if_id_queue_pkg.sv
// Shared instruction-format definitions for the fetch/decode boundary.
// Field slices live here once so the decoder and the immediate extender agree.
package if_id_queue_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int F7_LSB  = 25;
  localparam int F7_MSB  = 31;

  function automatic logic [6:0] f_opcode(input logic [31:0] i);
    return i[OPC_MSB:OPC_LSB];
  endfunction
  function automatic logic [4:0] f_rd(input logic [31:0] i);
    return i[RD_MSB:RD_LSB];
  endfunction
  function automatic logic [2:0] f_funct3(input logic [31:0] i);
    return i[F3_MSB:F3_LSB];
  endfunction
  function automatic logic [4:0] f_rs1(input logic [31:0] i);
    return i[RS1_MSB:RS1_LSB];
  endfunction
  function automatic logic [4:0] f_rs2(input logic [31:0] i);
    return i[RS2_MSB:RS2_LSB];
  endfunction
  function automatic logic [6:0] f_funct7(input logic [31:0] i);
    return i[F7_MSB:F7_LSB];
  endfunction

  // Raw immediate fields; sign extension is left to the extender.
  function automatic logic [11:0] f_iimm(input logic [31:0] i);
    return i[31:20];
  endfunction
  function automatic logic [11:0] f_simm(input logic [31:0] i);
    return {i[31:25], i[11:7]};
  endfunction
  function automatic logic [11:0] f_bimm(input logic [31:0] i);
    return {i[31], i[7], i[30:25], i[11:8]};
  endfunction
  function automatic logic [19:0] f_uimm(input logic [31:0] i);
    return i[31:12];
  endfunction
  function automatic logic [19:0] f_jimm(input logic [31:0] i);
    return {i[31], i[19:12], i[20], i[30:21]};
  endfunction

endpackage

// File: rtl/if_id_queue_sync_fifo.sv
// Generic circular-buffer FIFO with push/pop/flush; head is read combinationally.
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Redirect: drop everything, read side catches up to write side.
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  a_count_range: assert property (@(posedge clk) disable iff (!rstn)
    count_q <= (AW+1)'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
    !(pop && !flush && empty));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !flush && !pop && full));

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue: FIFO of {pc, instr} with NOP substitution
// when empty and pre-sliced instruction fields for the decoder.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  input  logic [31:0]     if_instr,
  output logic            if_ready,
  input  logic            flush,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [4:0]      iimm_shamt,
  output logic [11:0]     iimm,
  output logic [11:0]     simm,
  output logic [11:0]     bimm,
  output logic [19:0]     uimm,
  output logic [19:0]     jimm
);
  logic                   push, pop, full, empty;
  logic [PC_W+31:0]       head;
  logic [$clog2(DEPTH):0] count;

  // Ready depends on registered occupancy only, so no path from id_ready.
  assign if_ready = !full;
  assign id_valid = !empty;
  assign push     = if_valid && if_ready && !flush;
  assign pop      = id_valid && id_ready && !flush;

  sync_fifo #(.DEPTH(DEPTH), .W(PC_W+32)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({if_pc, if_instr}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign id_pc    = id_valid ? head[PC_W+31:32] : '0;
  assign id_instr = id_valid ? head[31:0]       : NOP_INSTR;

  assign opcode     = f_opcode(id_instr);
  assign rd         = f_rd(id_instr);
  assign funct3     = f_funct3(id_instr);
  assign rs1        = f_rs1(id_instr);
  assign rs2        = f_rs2(id_instr);
  assign funct7     = f_funct7(id_instr);
  assign iimm_shamt = f_rs2(id_instr);
  assign iimm       = f_iimm(id_instr);
  assign simm       = f_simm(id_instr);
  assign bimm       = f_bimm(id_instr);
  assign uimm       = f_uimm(id_instr);
  assign jimm       = f_jimm(id_instr);

  a_hold_stable: assert property (@(posedge clk) disable iff (!rstn)
    (id_valid && !id_ready && !flush) |=> (id_valid && $stable(id_pc) && $stable(id_instr)));
  a_count_le_depth: assert property (@(posedge clk) disable iff (!rstn)
    count <= ($clog2(DEPTH)+1)'(DEPTH));

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: queue-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_if_id_queue;
  localparam int DEPTH = 2;
  localparam int PC_W  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 0, rstn = 0;
  logic if_valid = 0, flush = 0, id_ready = 0;
  logic [31:0] if_pc = 0, if_instr = 0;
  logic if_ready, id_valid;
  logic [31:0] id_pc, id_instr;
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2, iimm_shamt;
  logic [2:0] funct3;
  logic [11:0] iimm, simm, bimm;
  logic [19:0] uimm, jimm;

  int nvec = 0, nerr = 0;
  bit chk_en = 0;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t mq[$];

  if_id_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rstn(rstn), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready), .flush(flush), .id_ready(id_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_instr(id_instr), .opcode(opcode), .rd(rd), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .funct7(funct7), .iimm_shamt(iimm_shamt), .iimm(iimm),
    .simm(simm), .bimm(bimm), .uimm(uimm), .jimm(jimm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bounded queue, readiness from occupancy before the edge.
  always @(posedge clk) begin
    if (!rstn || flush) mq.delete();
    else begin
      bit do_pop, do_push;
      ent_t e;
      do_pop  = (mq.size() != 0) && id_ready;
      do_push = if_valid && (mq.size() < DEPTH);
      e.pc = if_pc; e.instr = if_instr;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] ei, ep;
      ei = (mq.size() != 0) ? mq[0].instr : NOP;
      ep = (mq.size() != 0) ? mq[0].pc    : 32'h0;
      chk("m_if_ready", 64'(if_ready), 64'(mq.size() < DEPTH));
      chk("m_id_valid", 64'(id_valid), 64'(mq.size() != 0));
      chk("m_id_pc",    64'(id_pc),    64'(ep));
      chk("m_id_instr", 64'(id_instr), 64'(ei));
      chk("m_fields", {opcode, rd, funct3, rs1, rs2, funct7, iimm_shamt},
          64'({ei[6:0], ei[11:7], ei[14:12], ei[19:15], ei[24:20], ei[31:25], ei[24:20]}));
      chk("m_imm_is", {iimm, simm}, 64'({ei[31:20], ei[31:25], ei[11:7]}));
      chk("m_imm_buj", {bimm, uimm, jimm},
          64'({ei[31], ei[7], ei[30:25], ei[11:8], ei[31:12], ei[31], ei[19:12], ei[20], ei[30:21]}));
    end
  end

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl, input logic rn);
    if_valid = v; if_pc = pc; if_instr = ins; id_ready = rdy; flush = fl; rstn = rn;
    @(posedge clk); #1;
  endtask

  initial begin
    // 1: reset, with fetch offering an entry that must be ignored
    step(1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0);
    chk_en = 1;
    step(1, 32'h104, 32'hDEAD_BEEF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd1);
    chk("rst_id_instr", 64'(id_instr), 64'h13);
    chk("rst_id_pc",    64'(id_pc),    64'h0);
    chk("rst_rd_iimm",  {rd, iimm},    64'h0);

    // 2: beq push, decode stalled
    step(1, 32'h4, 32'hFE00_0EE3, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("beq_valid",  64'(id_valid), 64'd1);
    chk("beq_pc",     64'(id_pc),    64'h4);
    chk("beq_bimm",   64'(bimm),     64'hFFE);
    chk("beq_opcode", 64'(opcode),   64'h63);
    chk("beq_simm",   64'(simm),     64'hFFD);
    step(0, 0, 0, 1, 0, 1);
    chk("beq_drained", 64'(id_valid), 64'd0);

    // 3: three offers into a depth-2 queue
    step(1, 32'h8,  32'h1234_50B7, 0, 0, 1);
    step(1, 32'hC,  32'h0080_006F, 0, 0, 1);
    chk("full_if_ready", 64'(if_ready), 64'd0);
    step(1, 32'h10, 32'h0030_9093, 0, 0, 1);
    chk("lui_pc",   64'(id_pc), 64'h8);
    chk("lui_uimm", 64'(uimm),  64'h12345);
    chk("lui_rd",   64'(rd),    64'h1);
    step(0, 0, 0, 1, 0, 1);
    chk("jal_pc",   64'(id_pc), 64'hC);
    chk("jal_jimm", 64'(jimm),  64'h00004);

    // 4: refill to full, then pop and offer together
    step(1, 32'h10, 32'h0030_9093, 0, 0, 1);
    chk("refull_if_ready", 64'(if_ready), 64'd0);
    step(1, 32'h14, 32'h0000_0013, 1, 0, 1);
    chk("fullpop_pc",       64'(id_pc),    64'h10);
    chk("fullpop_if_ready", 64'(if_ready), 64'd1);
    chk("fullpop_shamt",    64'(iimm_shamt), 64'h3);
    step(0, 0, 0, 1, 0, 1);
    chk("fullpop_drained",  64'(id_valid), 64'd0);

    // 5: streaming, push and pop every cycle
    for (int k = 0; k < 16; k++) begin
      step(1, 32'(4*k), 32'h0000_0093 | (32'(k) << 20), 1, 0, 1);
      chk("stream_pc",    64'(id_pc),    64'(4*k));
      chk("stream_ready", {id_valid, if_ready}, 64'b11);
    end
    step(0, 0, 0, 1, 0, 1);
    chk("stream_drained", 64'(id_valid), 64'd0);

    // 6: flush with concurrent push and pop
    step(1, 32'h40, 32'h0010_0093, 0, 0, 1);
    step(1, 32'h44, 32'h0020_0093, 0, 0, 1);
    step(1, 32'h48, 32'h0030_0093, 1, 1, 1);
    chk("flush_valid",    64'(id_valid), 64'd0);
    chk("flush_instr",    64'(id_instr), 64'h13);
    chk("flush_if_ready", 64'(if_ready), 64'd1);
    step(1, 32'h80, 32'h0050_0093, 0, 0, 1);
    chk("postflush_pc",   64'(id_pc),    64'h80);
    chk("postflush_iimm", 64'(iimm),     64'h005);

    // flush together with reset: reset wins, same empty state
    step(1, 32'h84, 32'h0060_0093, 0, 1, 0);
    chk("rstflush_valid", 64'(id_valid), 64'd0);
    step(0, 0, 0, 0, 0, 1);
    chk("rstflush_pc",    64'(id_pc),    64'h0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling buffer between instruction fetch and the decode stage; holds fetched {pc, instr} pairs in a small FIFO.
- Presents the head entry to decode together with the pre-sliced instruction fields: register indices, opcode/funct, and the raw I/S/B/U/J/shamt immediate fields that the immediate extender consumes.
- Absorbs decode stalls without dropping fetches.
- Supports a single-cycle flush for branch/jump redirect.

Parameters:
- DEPTH, 2, number of entries; power of two, at least 2.
- PC_W, 32, program-counter width.
- NOP_INSTR, 32'h0000_0013, instruction word presented when the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  synchronous active-low reset.
- if_valid  in  1  fetch offers an entry this cycle.
- if_pc  in  PC_W  PC of the offered instruction.
- if_instr  in  32  offered instruction word.
- if_ready  out  1  queue accepts an entry this cycle.
- flush  in  1  discard all held entries (redirect).
- id_ready  in  1  decode consumes the head entry this cycle.
- id_valid  out  1  head entry is valid.
- id_pc  out  PC_W  head PC.
- id_instr  out  32  head instruction word.
- opcode  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- funct3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- funct7  out  7  instr[31:25].
- iimm_shamt  out  5  instr[24:20].
- iimm  out  12  instr[31:20].
- simm  out  12  {instr[31:25], instr[11:7]}.
- bimm  out  12  {instr[31], instr[7], instr[30:25], instr[11:8]}.
- uimm  out  20  instr[31:12].
- jimm  out  20  {instr[31], instr[19:12], instr[20], instr[30:21]}.

Behaviour:
- Storage and pointers:
  - Circular buffer with wr_ptr, rd_ptr (log2 DEPTH bits, wrap naturally) and count (0..DEPTH).
  - Reset (rstn=0 at a clock edge): count=0, wr_ptr=0, rd_ptr=0. Data RAM is not cleared.
  - After reset: if_ready=1, id_valid=0, id_pc=0, id_instr=NOP_INSTR, and the field outputs are those of NOP_INSTR.
  - Reset has priority over flush, push and pop.
- Push and pop:
  - if_ready = (count != DEPTH), decoded from registered count. It is combinational from state only, never from id_ready or flush.
  - push = if_valid & if_ready & ~flush.
  - pop = id_valid & id_ready & ~flush.
  - id_valid = (count != 0).
- Head outputs:
  - id_pc / id_instr come from the head entry when id_valid=1.
  - When id_valid=0: id_pc=0, id_instr=NOP_INSTR.
  - All field outputs are pure bit-slices of id_instr, with no sign extension (the extender does that).
  - Read latency is zero: the head is combinational from the buffer.
  - Push-to-visible latency is 1 cycle: an entry written at edge N appears at the head after edge N if the queue was empty.
- Simultaneous events:
  - push and pop together: count unchanged, both pointers advance.
  - Full and pop: no push that cycle because if_ready=0. Space is visible on the next cycle.
  - Empty: no pop possible. No bypass, so an empty-queue push is not visible until the next cycle.
- Flush:
  - At the edge: count=0, rd_ptr=wr_ptr (pointer values otherwise unchanged).
  - Any concurrent push or pop is ignored.
  - id_valid=0 the following cycle.
  - Flush and reset together: reset wins (same end state).
- Invariants checked by assertions:
  - count never exceeds DEPTH or underflows.
  - Entries come out in FIFO order.
  - id_* outputs are stable while id_valid=1 and id_ready=0.

Decomposition:
- Shared package/header holds:
  - NOP_INSTR constant.
  - Opcode field bit positions.
  - Immediate-field slice macros, reused by the decoder and the immediate extender so the slicing is defined once.
- One natural sub-module: sync_fifo (generic DEPTH x width storage with push/pop/flush and count).
- if_id_queue instantiates sync_fifo with width PC_W+32 and adds the empty-NOP substitution and field slicing.

Test Plan:
1. Reset → id_valid=0, if_ready=1, id_instr=32'h00000013, rd=0, iimm=12'h000. Hold rstn=0 while if_valid=1 → nothing enqueued.
2. Push pc=32'h0000_0004, instr=32'hFE00_0EE3 (beq x0,x0,-4) with id_ready=0 → next cycle id_valid=1, id_pc=4, bimm=12'hFFE, opcode=7'h63, simm=12'hFFD.
3. Push three entries (instr 32'h1234_50B7, 32'h0080_006F, 32'h0030_9093) with id_ready=0 → third refused since if_ready=0 after two. Then:
   - lui head: uimm=20'h12345, rd=1.
   - after one pop: jal head: jimm=20'h00004.
   - slli presented only if re-pushed.
4. Queue full, id_ready=1 and if_valid=1 in the same cycle → one pop, no push; count=1; if_ready=1 on the next cycle.
5. Push/pop every cycle for 16 cycles with incrementing PCs 0,4,...,60 → output PCs in order, count constant at 1, no gaps after the first-cycle latency.
6. Queue holds 2 entries; flush=1 with if_valid=1 and id_ready=1 → next cycle id_valid=0, count=0, id_instr=NOP_INSTR. A subsequent push appears one cycle later with the correct PC.
